// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the instruction cache.
// Address split: offset [1:0], word, index, tag (upper bits).
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } ic_state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic int wo_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int words);
    return 30 - $clog2(words) - $clog2(lines);
  endfunction

endpackage

// File: rtl/instr_cache_array.sv
// Flop-based valid/tag/data storage for the instruction cache.
// One combinational read port, one word write port, flush-all.
module instr_cache_array import icache_pkg::*; #(
  parameter int LINES = 16,
  parameter int WORDS = 4,
  parameter int IW    = idx_w(LINES),
  parameter int WW    = wo_w(WORDS),
  parameter int TW    = tag_w(LINES, WORDS)
) (
  input  logic          i_clk,
  input  logic          i_nrst,
  input  logic [IW-1:0] i_rd_idx,
  input  logic [WW-1:0] i_rd_wo,
  output logic          o_rd_valid,
  output logic [TW-1:0] o_rd_tag,
  output logic [31:0]   o_rd_data,
  input  logic          i_wr_en,
  input  logic [IW-1:0] i_wr_idx,
  input  logic [WW-1:0] i_wr_wo,
  input  logic [31:0]   i_wr_data,
  input  logic          i_set_en,
  input  logic [TW-1:0] i_set_tag,
  input  logic          i_flush
);

  logic [LINES-1:0] r_valid;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES][WORDS];

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_data  = r_data[i_rd_idx][i_rd_wo];

  // Valid bits: flush beats a same-cycle validate.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_set_en) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_wo] <= i_wr_data;
    end
    if (i_set_en) begin
      r_tag[i_wr_idx] <= i_set_tag;
    end
  end

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache.
// Zero-latency hits; word-by-word refill over valid/ready memory bus.
module instr_cache import icache_pkg::*; #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req,
  input  logic [31:0] i_addr_pc,
  input  logic        i_flush,
  output logic        o_valid,
  output logic        o_stall,
  output logic [31:0] o_data_instr,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ready,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int IW = idx_w(LINES);
  localparam int WW = wo_w(WORDS);
  localparam int TW = tag_w(LINES, WORDS);

  ic_state_e     r_state, w_state_nx;
  logic [WW-1:0] r_cnt, w_cnt_nx;
  logic [31:0]   r_base, w_base_nx;
  logic          r_abort, w_abort_nx;

  logic [IW-1:0] w_idx, w_ref_idx;
  logic [WW-1:0] w_wo;
  logic [TW-1:0] w_tag, w_ref_tag, w_rd_tag;
  logic [31:0]   w_rd_data;
  logic          w_rd_valid, w_hit, w_miss;
  logic          w_wr_en, w_set_en, w_mem_req;
  logic          w_unused_ofs;

  assign w_wo      = i_addr_pc[WW+1:2];
  assign w_idx     = i_addr_pc[WW+2 +: IW];
  assign w_tag     = i_addr_pc[31 -: TW];
  assign w_ref_idx = r_base[WW+2 +: IW];
  assign w_ref_tag = r_base[31 -: TW];
  assign w_unused_ofs = ^i_addr_pc[1:0];

  assign w_hit = i_req & w_rd_valid & (w_rd_tag == w_tag)
               & (r_state == IDLE) & ~i_flush;
  assign w_miss = i_req & ~w_hit;

  assign o_valid      = w_hit;
  assign o_stall      = w_miss;
  assign o_data_instr = w_hit ? w_rd_data : NOP;
  assign o_mem_req    = w_mem_req;
  assign o_mem_addr   = w_mem_req ? r_base + 32'({r_cnt, 2'b00}) : '0;

  instr_cache_array #(
    .LINES (LINES),
    .WORDS (WORDS)
  ) u_array (
    .i_clk      (i_clk),
    .i_nrst     (i_nrst),
    .i_rd_idx   (w_idx),
    .i_rd_wo    (w_wo),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_ref_idx),
    .i_wr_wo    (r_cnt),
    .i_wr_data  (i_mem_rdata),
    .i_set_en   (w_set_en),
    .i_set_tag  (w_ref_tag),
    .i_flush    (i_flush)
  );

  // Refill FSM: next state, counter, line base and bus controls.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_base_nx  = r_base;
    w_mem_req  = 1'b0;
    w_wr_en    = 1'b0;
    w_set_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_miss && !i_flush) begin
          w_state_nx = REQ;
          w_cnt_nx   = '0;
          w_base_nx  = {i_addr_pc[31:WW+2], {(WW+2){1'b0}}};
        end
      end
      REQ: begin
        w_mem_req = 1'b1;
        if (i_mem_ready) w_state_nx = WAIT;
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          w_wr_en = 1'b1;
          if (r_cnt == WW'(WORDS - 1)) begin
            w_set_en   = ~r_abort;
            w_state_nx = IDLE;
          end else begin
            w_cnt_nx   = r_cnt + WW'(1);
            w_state_nx = REQ;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
    w_abort_nx = (w_state_nx == IDLE) ? 1'b0
               : (r_abort | (i_flush & (r_state != IDLE)));
  end

  // FSM state and refill bookkeeping registers.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_base  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_base  <= w_base_nx;
      r_abort <= w_abort_nx;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Directed self-checking bench for instr_cache.
// Inputs driven and outputs sampled on the falling edge.
module tb_instr_cache;

  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic        i_clk;
  logic        i_nrst;
  logic        i_req;
  logic [31:0] i_addr_pc;
  logic        i_flush;
  logic        o_valid;
  logic        o_stall;
  logic [31:0] o_data_instr;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  int total = 0;
  int bad   = 0;

  instr_cache #(
    .LINES (16),
    .WORDS (4)
  ) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_req        (i_req),
    .i_addr_pc    (i_addr_pc),
    .i_flush      (i_flush),
    .o_valid      (o_valid),
    .o_stall      (o_stall),
    .o_data_instr (o_data_instr),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a[31:4] == 28'h000_0010) return 32'hA0 + 32'(a[3:2]);
    return 32'hB000_0000 | a;
  endfunction

  // Serve one line refill; entered at the falling edge of the first REQ cycle.
  task automatic refill(input logic [31:0] base, input int dly,
                        input bit flush2);
    logic [31:0] ea;
    for (int w = 0; w < 4; w++) begin
      ea = base + 32'(w * 4);
      for (int d = 0; d < dly; d++) begin
        i_mem_ready = 1'b0;
        #1;
        total++;
        if (o_mem_req !== 1'b1 || o_mem_addr !== ea || o_stall !== 1'b1
            || o_valid !== 1'b0 || o_data_instr !== NOP_W) begin
          bad++;
          $display("FAIL hold w=%0d: req=%b addr=%h stall=%b valid=%b data=%h, want 1 %h 1 0 %h",
                   w, o_mem_req, o_mem_addr, o_stall, o_valid, o_data_instr, ea, NOP_W);
        end
        @(negedge i_clk);
      end
      i_mem_ready = 1'b1;
      #1;
      total++;
      if (o_mem_req !== 1'b1 || o_mem_addr !== ea || o_stall !== 1'b1) begin
        bad++;
        $display("FAIL req w=%0d: req=%b addr=%h stall=%b, want 1 %h 1",
                 w, o_mem_req, o_mem_addr, o_stall, ea);
      end
      @(negedge i_clk);
      i_mem_ready  = 1'b0;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = mem_val(ea);
      i_flush      = flush2 && (w == 2);
      #1;
      total++;
      if (o_mem_req !== 1'b0 || o_stall !== 1'b1 || o_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait w=%0d: req=%b stall=%b valid=%b, want 0 1 0",
                 w, o_mem_req, o_stall, o_valid);
      end
      @(negedge i_clk);
      i_mem_rvalid = 1'b0;
      i_flush      = 1'b0;
    end
  endtask

  task automatic test_reset;
    i_nrst = 1'b0; i_req = 1'b1; i_addr_pc = 32'h100; i_flush = 1'b0;
    i_mem_ready = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    #1;
    total++;
    if (o_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %b want 0", o_valid);
    end
    total++;
    if (o_stall !== 1'b1) begin
      bad++; $display("FAIL rst_stall: got %b want 1", o_stall);
    end
    total++;
    if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin
      bad++; $display("FAIL rst_mem: got %b %h want 0 0", o_mem_req, o_mem_addr);
    end
    total++;
    if (o_data_instr !== NOP_W) begin
      bad++; $display("FAIL rst_data: got %h want %h", o_data_instr, NOP_W);
    end
    i_req = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  // Detect a miss at pc, serve the refill, then check the hit word.
  task automatic miss_fill(input logic [31:0] pc, input int dly);
    @(negedge i_clk);
    i_req = 1'b1; i_addr_pc = pc;
    #1;
    total++;
    if (o_stall !== 1'b1 || o_valid !== 1'b0 || o_mem_req !== 1'b0
        || o_data_instr !== NOP_W) begin
      bad++;
      $display("FAIL miss_det %h: stall=%b valid=%b req=%b data=%h, want 1 0 0 %h",
               pc, o_stall, o_valid, o_mem_req, o_data_instr, NOP_W);
    end
    @(negedge i_clk);
    refill(pc, dly, 1'b0);
    #1;
    total++;
    if (o_valid !== 1'b1 || o_stall !== 1'b0 || o_data_instr !== mem_val(pc)) begin
      bad++;
      $display("FAIL fill_hit %h: valid=%b stall=%b data=%h, want 1 0 %h",
               pc, o_valid, o_stall, o_data_instr, mem_val(pc));
    end
    i_req = 1'b0;
  endtask

  task automatic test_cold_miss;
    miss_fill(32'h100, 0);
    for (int k = 1; k < 4; k++) begin
      @(negedge i_clk);
      i_req = 1'b1; i_addr_pc = 32'h100 + 32'(k * 4);
      #1;
      total++;
      if (o_valid !== 1'b1 || o_data_instr !== 32'hA0 + 32'(k)
          || o_mem_req !== 1'b0 || o_stall !== 1'b0) begin
        bad++;
        $display("FAIL seq_hit k=%0d: valid=%b data=%h req=%b stall=%b, want 1 %h 0 0",
                 k, o_valid, o_data_instr, o_mem_req, o_stall, 32'hA0 + 32'(k));
      end
    end
    i_req = 1'b0;
  endtask

  task automatic test_conflict;
    miss_fill(32'h200, 0);
    miss_fill(32'h100, 0);
  endtask

  task automatic test_backpressure;
    miss_fill(32'h140, 5);
  endtask

  task automatic test_flush;
    @(negedge i_clk);
    i_req = 1'b1; i_addr_pc = 32'h300;
    @(negedge i_clk);
    refill(32'h300, 0, 1'b1);
    #1;
    total++;
    if (o_valid !== 1'b0 || o_stall !== 1'b1) begin
      bad++;
      $display("FAIL flush_noval: valid=%b stall=%b, want 0 1", o_valid, o_stall);
    end
    @(negedge i_clk);
    refill(32'h300, 0, 1'b0);
    #1;
    total++;
    if (o_valid !== 1'b1 || o_data_instr !== 32'hB000_0300) begin
      bad++;
      $display("FAIL refetch_hit: valid=%b data=%h, want 1 b0000300",
               o_valid, o_data_instr);
    end
    @(negedge i_clk);
    i_addr_pc = 32'h140;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_stall !== 1'b1) begin
      bad++;
      $display("FAIL flushed_140: valid=%b stall=%b, want 0 1", o_valid, o_stall);
    end
    i_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge i_clk);
    i_req = 1'b1; i_addr_pc = 32'h100;
    @(negedge i_clk);
    #1;
    total++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100) begin
      bad++;
      $display("FAIL mid_req: req=%b addr=%h, want 1 00000100", o_mem_req, o_mem_addr);
    end
    i_nrst = 1'b0;
    @(negedge i_clk);
    i_nrst = 1'b1; i_req = 1'b0;
    #1;
    total++;
    if (o_mem_req !== 1'b0 || o_data_instr !== NOP_W || o_stall !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst: req=%b data=%h stall=%b, want 0 %h 0",
               o_mem_req, o_data_instr, o_stall, NOP_W);
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    #1;
    total++;
    if (o_mem_req !== 1'b0) begin
      bad++; $display("FAIL stray_rv: req=%b want 0", o_mem_req);
    end
    @(negedge i_clk);
    i_mem_rvalid = 1'b0;
    i_req = 1'b1; i_addr_pc = 32'h300;
    #1;
    total++;
    if (o_valid !== 1'b0 || o_stall !== 1'b1 || o_mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_inval: valid=%b stall=%b req=%b, want 0 1 0",
               o_valid, o_stall, o_mem_req);
    end
    i_req = 1'b0;
  endtask

  task automatic test_idle;
    @(negedge i_clk);
    i_req = 1'b0; i_addr_pc = 32'h100;
    #1;
    total++;
    if (o_stall !== 1'b0 || o_mem_req !== 1'b0 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_out: stall=%b req=%b valid=%b, want 0 0 0",
               o_stall, o_mem_req, o_valid);
    end
    @(negedge i_clk);
    #1;
    total++;
    if (o_mem_req !== 1'b0) begin
      bad++; $display("FAIL idle_stay: req=%b want 0", o_mem_req);
    end
    miss_fill(32'h100, 0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
# instr_cache

Direct-mapped, read-only instruction cache that answers the fetch stage's PC requests and refills missing lines from the instruction memory bus. Sits between the fetch stage and main memory: fetch drives a PC and samples an instruction word, and this block returns that word on a hit. On a miss it stalls fetch, runs a word-by-word refill over a valid/ready memory interface, then serves the hit.

## Interface
Parameters:
- LINES, 16, number of cache lines (power of two, ≥2)
- WORDS, 4, 32-bit words per line (power of two, ≥2)

Ports:
- i_clk  in  1  clock; all state updates on posedge
- i_nrst  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request valid
- i_addr_pc  in  32  fetch address; bits [1:0] ignored
- i_flush  in  1  invalidate all lines (fence.i)
- o_valid  out  1  o_data_instr holds the requested word this cycle
- o_stall  out  1  request pending, not served; fetch holds PC
- o_data_instr  out  32  instruction word; 32'h0000_0013 (NOP) when o_valid=0
- o_mem_req  out  1  memory read request valid
- o_mem_addr  out  32  word-aligned memory read address
- i_mem_ready  in  1  memory accepts request (handshake when o_mem_req & i_mem_ready)
- i_mem_rvalid  in  1  read data valid
- i_mem_rdata  in  32  read data

## Operation
- Address split: offset [1:0]; word WO=[log2(WORDS)+1:2]; index next log2(LINES) bits; tag = remaining upper bits.
- Storage: per line valid bit, tag, WORDS data words, all in flops. Lookup is combinational.
- Hit = i_req & valid[index] & tag match & state IDLE & ~i_flush. On hit: o_valid=1, o_data_instr = data[index][WO], o_stall=0.
- o_stall = i_req & ~hit. i_req=0 → o_valid=0, o_stall=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: i_req & miss & ~i_flush → latch line base (WO and offset zeroed), cnt=0 → REQ.
  - REQ: o_mem_req=1, o_mem_addr = base + 4*cnt. On i_mem_ready → WAIT.
  - WAIT: on i_mem_rvalid write i_mem_rdata to data[latched index][cnt]. If cnt==WORDS-1, set tag and valid for the line (unless an abort is flagged) → IDLE. Otherwise cnt++ → REQ.
- One memory request outstanding at a time. i_mem_rvalid outside WAIT is ignored.
- PC changes during refill are ignored. The latched line completes, then the new PC is looked up in IDLE.
- i_flush, any state: clears all valid bits that cycle and has priority over a same-cycle validate.
  - During REQ/WAIT, the refill drains to completion but the line is not validated (abort flag set, cleared on return to IDLE).
- Memory address arithmetic is 32-bit, no wrap handling needed (line-aligned base).

## Timing
- Reset (i_nrst=0 at posedge): state IDLE, all valid=0, cnt=0, abort=0. Outputs: o_valid=0, o_stall=i_req, o_mem_req=0, o_mem_addr=0, o_data_instr=NOP. Tag/data arrays are not reset.
- Reset mid-refill: FSM returns to IDLE next cycle. No line is validated. Late i_mem_rvalid is ignored.
- Hit latency: 0 cycles (combinational from registered arrays).
- Miss with i_mem_ready=1 at once and i_mem_rvalid one cycle after acceptance: 2 cycles per word. The line is valid after the last WAIT edge. Fetch sees a hit in the cycle after the FSM returns to IDLE; total miss penalty with WORDS=4 is 9 cycles including the detection cycle.
- o_mem_req and o_mem_addr are held stable in REQ until accepted.

## Structure
- Package icache_pkg: state enum (IDLE, REQ, WAIT); NOP constant 32'h0000_0013; localparams/functions for index, word and tag widths derived from LINES and WORDS.
- Sub-module instr_cache_array: valid/tag/data flops, combinational read port (index, word), single write port (index, word, data), tag-set/validate and flush-all inputs. The top holds the FSM, counter, handshake and hit logic.

## Test plan
- Cold miss: i_req=1, PC=0x100, memory returns 0xA0,0xA1,0xA2,0xA3 for 0x100..0x10C → four requests to 0x100/104/108/10C; then o_valid=1 with o_data_instr=0xA0. PC 0x104/0x108/0x10C hit with 0xA1/0xA2/0xA3 in consecutive cycles, no o_mem_req.
- Conflict: after the line at 0x100, fetch 0x200 (LINES=16, WORDS=4, same index 0) → miss and refill. Then 0x100 misses again.
- Backpressure: i_mem_ready low 5 cycles in REQ → o_mem_addr stable, o_stall=1, o_valid=0 throughout; completes normally afterwards.
- Flush: i_flush pulse while refill of 0x300 is in WAIT with cnt=2 → refill finishes (4 words accepted), line not valid. Re-fetch of 0x300 misses. Previously cached 0x100 also misses.
- Reset mid-refill: i_nrst low during REQ → next cycle o_mem_req=0, o_data_instr=0x00000013. A stray i_mem_rvalid afterwards writes nothing. Fetch of 0x100 misses.
- Idle: i_req=0 with a miss address → o_stall=0, o_mem_req=0, FSM stays IDLE.
